// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one memory request at a time,
// buffers returned words in a small FIFO and hands them to execute as IR.
// Supports redirect (flush + new PC) and stops fetching on a HALT opcode.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [4:0]        HALT_OP  = 5'b11111
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              start,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_valid,
   output logic [31:0]       ir,
   output logic              ir_valid,
   input  logic              ir_ready,
   input  logic              redirect_en,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_STALL, S_DRAIN, S_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
   logic              discard_q, discard_d;
   logic [31:0]       buf_q [DEPTH];

   logic pop, push, flush, rsp_halt;

   // Buffer handshake events and response classification for this cycle.
   always_comb begin
      pop      = (count_q != '0) && ir_ready;
      flush    = redirect_en && (state_q != S_IDLE);
      rsp_halt = (imem_rdata[31:27] == HALT_OP);
      // A response coincident with a redirect is dropped, as is a HALT word.
      push     = (state_q == S_WAIT) && imem_valid && !redirect_en && !rsp_halt;
   end

   // Next PC and FIFO bookkeeping; a redirect always wins over the increment.
   always_comb begin
      pc_d    = pc_q;
      count_d = count_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      if (redirect_en) begin
         pc_d = redirect_pc;
      end else if ((state_q == S_WAIT) && imem_valid) begin
         pc_d = pc_q + 1'b1;
      end
      if (flush) begin
         count_d = '0;
         rd_d    = '0;
         wr_d    = '0;
      end else begin
         if (pop)  rd_d = rd_q + 1'b1;
         if (push) wr_d = wr_q + 1'b1;
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Next-state logic; count_d already reflects this cycle's push and pop.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_ISSUE;
         // The pulse already on the bus stays outstanding across a redirect.
         S_ISSUE: state_d = redirect_en ? S_DRAIN : S_WAIT;
         S_WAIT: begin
            if (redirect_en) begin
               state_d = imem_valid ? S_ISSUE : S_DRAIN;
            end else if (imem_valid) begin
               if (rsp_halt)             state_d = S_HALT;
               else if (count_d < FULL)  state_d = S_ISSUE;
               else                      state_d = S_STALL;
            end
         end
         S_STALL: if (redirect_en || (count_d < FULL)) state_d = S_ISSUE;
         S_DRAIN: if (imem_valid && discard_q) state_d = S_ISSUE;
         S_HALT:  if (redirect_en) state_d = S_ISSUE;
         default: state_d = S_IDLE;
      endcase
      discard_d = (state_d == S_DRAIN);
   end

   // Control state register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         count_q   <= '0;
         rd_q      <= '0;
         wr_q      <= '0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         count_q   <= count_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         discard_q <= discard_d;
      end
   end

   // Instruction storage; contents are only visible while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) buf_q[wr_q] <= imem_rdata;
   end

   // Outputs decoded from registered state only.
   always_comb begin
      imem_req  = (state_q == S_ISSUE);
      imem_addr = (state_q == S_ISSUE) ? pc_q : '0;
      ir_valid  = (count_q != '0);
      ir        = (count_q != '0) ? buf_q[rd_q] : '0;
      halted    = (state_q == S_HALT) && (count_q == '0);
      pc        = pc_q;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch unit.
module tb_instr_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk = 1'b0;
   logic        sys_rst, start, imem_req, imem_valid, ir_valid, ir_ready, redirect_en, halted;
   logic [15:0] imem_addr, redirect_pc, pc;
   logic [31:0] imem_rdata, ir;

   int checks = 0;
   int failures = 0;

   // memory environment
   logic [31:0] memw [0:65535];
   int          mem_lat = 1;
   bit          mem_rand = 1'b0;
   bit          mem_kill = 1'b0;
   bit          pend = 1'b0;
   int          cnt = 0;
   logic [15:0] paddr = '0;
   int          req_cnt = 0;
   logic [15:0] req_log [0:255];
   int          proto_err = 0;

   instr_fetch_unit #(.ADDR_W(16), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .HALT_OP(5'b11111)) dut (
      .clk(clk), .sys_rst(sys_rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc), .pc(pc), .halted(halted)
   );

   always #5 clk = ~clk;

   // Single-outstanding memory: answers each request after a latency of >= 1 cycle.
   always @(negedge clk) begin
      imem_valid = 1'b0;
      if (mem_kill) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
               imem_valid = 1'b1;
               imem_rdata = memw[paddr];
               pend = 1'b0;
            end
         end
         if (imem_req) begin
            if (pend) proto_err = proto_err + 1;
            pend  = 1'b1;
            paddr = imem_addr;
            cnt   = mem_rand ? int'($urandom_range(4, 1)) : mem_lat;
            req_log[8'(req_cnt)] = imem_addr;
            req_cnt = req_cnt + 1;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      sys_rst = 1'b0; mem_kill = 1'b1; start = 1'b0; redirect_en = 1'b0;
      redirect_pc = '0; ir_ready = 1'b0; mem_rand = 1'b0; mem_lat = 1;
      repeat (2) @(negedge clk);
      sys_rst = 1'b1; mem_kill = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
      checks++; if (imem_addr !== 16'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
      checks++; if (ir !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=0", ir); end
      checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL reset_ir_valid got=%0b exp=0", ir_valid); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
      checks++; if (pc !== RESET_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RESET_PC); end
      start = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_hold_req got=%0b exp=0", imem_req); end
      start = 1'b0;
   endtask

   task automatic test_straight_line();
      logic [31:0] want [3];
      int base, nseen, i;
      logic prev;
      want[0] = 32'h08400005; want[1] = 32'h10820001; want[2] = 32'h20000000;
      do_reset();
      memw[0] = want[0]; memw[1] = want[1]; memw[2] = want[2];
      base = req_cnt; ir_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nseen = 0; i = 0; prev = 1'b0;
      while (nseen < 3 && i < 40) begin
         if (ir_valid) begin
            checks++; if (ir !== want[nseen]) begin failures++; $display("FAIL line_word%0d got=%h exp=%h", nseen, ir, want[nseen]); end
            checks++; if (prev) begin failures++; $display("FAIL line_valid_len word%0d valid for 2 cycles exp 1", nseen); end
            nseen++;
            if (nseen == 3) begin
               checks++; if (pc !== 16'(RESET_PC + 3)) begin failures++; $display("FAIL line_pc got=%h exp=%h", pc, 16'(RESET_PC + 3)); end
            end
         end
         prev = ir_valid;
         if (nseen < 3) @(negedge clk);
         i++;
      end
      checks++; if (nseen != 3) begin failures++; $display("FAIL line_timeout words=%0d exp=3", nseen); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (req_log[8'(base + k)] !== 16'(k)) begin
            failures++; $display("FAIL line_addr%0d got=%h exp=%h", k, req_log[8'(base + k)], 16'(k));
         end
      end
   endtask

   task automatic test_backpressure();
      int base;
      do_reset();
      base = req_cnt; ir_ready = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (req_cnt - base != 2) begin failures++; $display("FAIL bp_reqs got=%0d exp=2", req_cnt - base); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_stall_req got=%0b exp=0", imem_req); end
      checks++; if (ir_valid !== 1'b1 || ir !== memw[0]) begin failures++; $display("FAIL bp_head got=%0b/%h exp=1/%h", ir_valid, ir, memw[0]); end
      checks++; if (pc !== 16'h0002) begin failures++; $display("FAIL bp_pc got=%h exp=0002", pc); end
      ir_ready = 1'b1;
      @(negedge clk);
      ir_ready = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin failures++; $display("FAIL bp_reissue got=%0b/%h exp=1/0002", imem_req, imem_addr); end
      checks++; if (ir !== memw[1]) begin failures++; $display("FAIL bp_pop got=%h exp=%h", ir, memw[1]); end
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_one_pulse got=%0b exp=0", imem_req); end
      repeat (4) @(negedge clk);
      checks++; if (req_cnt - base != 3 || imem_req !== 1'b0) begin failures++; $display("FAIL bp_refill reqs=%0d req=%0b exp=3/0", req_cnt - base, imem_req); end
   endtask

   task automatic test_halt();
      logic [31:0] want [2];
      int base, nseen;
      bit hseen;
      want[0] = 32'h11111111; want[1] = 32'h22222222;
      do_reset();
      memw[0] = want[0]; memw[1] = want[1]; memw[2] = 32'hF8000000;
      base = req_cnt; ir_ready = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      checks++; if (halted !== 1'b0 || ir_valid !== 1'b1) begin failures++; $display("FAIL halt_early halted=%0b valid=%0b exp=0/1", halted, ir_valid); end
      ir_ready = 1'b1;
      nseen = 0; hseen = 1'b0;
      for (int i = 0; i < 30 && !hseen; i++) begin
         if (halted) begin
            checks++; if (ir_valid !== 1'b0 || nseen != 2) begin failures++; $display("FAIL halt_drain valid=%0b words=%0d exp=0/2", ir_valid, nseen); end
            hseen = 1'b1;
         end else begin
            if (ir_valid) begin
               checks++;
               if (nseen >= 2) begin failures++; $display("FAIL halt_extra_word got=%h exp=none", ir); end
               else if (ir !== want[nseen]) begin failures++; $display("FAIL halt_word%0d got=%h exp=%h", nseen, ir, want[nseen]); end
               nseen++;
            end
            @(negedge clk);
         end
      end
      checks++; if (!hseen) begin failures++; $display("FAIL halt_timeout halted=%0b exp=1", halted); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++; if (imem_req !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL halt_hold req=%0b halted=%0b exp=0/1", imem_req, halted); end
         @(negedge clk);
      end
      checks++; if (req_cnt - base != 3 || pc !== 16'h0003) begin failures++; $display("FAIL halt_final reqs=%0d pc=%h exp=3/0003", req_cnt - base, pc); end
   endtask

   task automatic wait_reqs(input int n);
      int seen;
      seen = 0;
      for (int i = 0; i < 40 && seen < n; i++) begin
         if (imem_req) seen++;
         if (seen < n) @(negedge clk);
      end
      checks++; if (seen != n) begin failures++; $display("FAIL wait_req_timeout got=%0d exp=%0d", seen, n); end
   endtask

   task automatic test_redirect_wait();
      int pe0;
      bit gotreq, gotv;
      do_reset();
      memw[16'h0040] = 32'h0A0B0C0D;
      pe0 = proto_err; mem_lat = 3; ir_ready = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_reqs(2);
      @(negedge clk);
      redirect_en = 1'b1; redirect_pc = 16'h0040;
      @(negedge clk);
      redirect_en = 1'b0;
      checks++; if (ir_valid !== 1'b0 || ir !== 32'h0) begin failures++; $display("FAIL rw_flush got=%0b/%h exp=0/0", ir_valid, ir); end
      checks++; if (pc !== 16'h0040 || imem_req !== 1'b0) begin failures++; $display("FAIL rw_drain pc=%h req=%0b exp=0040/0", pc, imem_req); end
      gotreq = 1'b0; gotv = 1'b0;
      for (int i = 0; i < 30 && !gotv; i++) begin
         if (imem_req && !gotreq) begin
            checks++; if (imem_addr !== 16'h0040) begin failures++; $display("FAIL rw_addr got=%h exp=0040", imem_addr); end
            gotreq = 1'b1;
         end
         if (ir_valid) begin
            checks++; if (ir !== memw[16'h0040]) begin failures++; $display("FAIL rw_word got=%h exp=%h", ir, memw[16'h0040]); end
            checks++; if (pc !== 16'h0041) begin failures++; $display("FAIL rw_pc got=%h exp=0041", pc); end
            gotv = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      checks++; if (!gotv || !gotreq) begin failures++; $display("FAIL rw_timeout req=%0b word=%0b exp=1/1", gotreq, gotv); end
      checks++; if (proto_err != pe0) begin failures++; $display("FAIL rw_outstanding got=%0d exp=%0d", proto_err, pe0); end
   endtask

   task automatic test_redirect_pop();
      bit gotv;
      do_reset();
      memw[16'h0080] = 32'h0C0FFEE0;
      mem_lat = 1; ir_ready = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_reqs(2);
      @(negedge clk);
      checks++; if (ir_valid !== 1'b1 || ir !== memw[0]) begin failures++; $display("FAIL rp_head got=%0b/%h exp=1/%h", ir_valid, ir, memw[0]); end
      redirect_en = 1'b1; redirect_pc = 16'h0080; ir_ready = 1'b1;
      @(negedge clk);
      redirect_en = 1'b0; ir_ready = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin failures++; $display("FAIL rp_issue got=%0b/%h exp=1/0080", imem_req, imem_addr); end
      checks++; if (ir_valid !== 1'b0 || pc !== 16'h0080) begin failures++; $display("FAIL rp_flush valid=%0b pc=%h exp=0/0080", ir_valid, pc); end
      gotv = 1'b0;
      for (int i = 0; i < 20 && !gotv; i++) begin
         if (ir_valid) begin
            checks++; if (ir !== memw[16'h0080] || pc !== 16'h0081) begin failures++; $display("FAIL rp_word got=%h pc=%h exp=%h/0081", ir, pc, memw[16'h0080]); end
            gotv = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      checks++; if (!gotv) begin failures++; $display("FAIL rp_timeout got=0 exp=1"); end
   endtask

   task automatic test_wrap_reset();
      do_reset();
      memw[16'hFFFF] = 32'h0123ABCD;
      redirect_en = 1'b1; redirect_pc = 16'hFFFF;
      @(negedge clk);
      redirect_en = 1'b0;
      checks++; if (pc !== 16'hFFFF || imem_req !== 1'b0) begin failures++; $display("FAIL wr_idle_load pc=%h req=%0b exp=ffff/0", pc, imem_req); end
      ir_ready = 1'b0; mem_lat = 1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF) begin failures++; $display("FAIL wr_issue got=%0b/%h exp=1/ffff", imem_req, imem_addr); end
      @(negedge clk);
      mem_lat = 4;
      @(negedge clk);
      checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL wr_wrap got=%h exp=0000", pc); end
      checks++; if (ir_valid !== 1'b1 || ir !== 32'h0123ABCD) begin failures++; $display("FAIL wr_word got=%0b/%h exp=1/0123abcd", ir_valid, ir); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin failures++; $display("FAIL wr_next got=%0b/%h exp=1/0000", imem_req, imem_addr); end
      @(negedge clk);
      #2 sys_rst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0) begin failures++; $display("FAIL ar_imem got=%0b/%h exp=0/0000", imem_req, imem_addr); end
      checks++; if (ir_valid !== 1'b0 || ir !== 32'h0) begin failures++; $display("FAIL ar_ir got=%0b/%h exp=0/0", ir_valid, ir); end
      checks++; if (halted !== 1'b0 || pc !== RESET_PC) begin failures++; $display("FAIL ar_state halted=%0b pc=%h exp=0/%h", halted, pc, RESET_PC); end
      @(negedge clk);
      sys_rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (imem_req !== 1'b0 || ir_valid !== 1'b0 || pc !== RESET_PC) begin
            failures++; $display("FAIL ar_late_rsp req=%0b valid=%0b pc=%h exp=0/0/%h", imem_req, ir_valid, pc, RESET_PC);
         end
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC || ir_valid !== 1'b0) begin
         failures++; $display("FAIL ar_restart got=%0b/%h/%0b exp=1/%h/0", imem_req, imem_addr, ir_valid, RESET_PC);
      end
   endtask

   task automatic test_random();
      logic [31:0] q [$];
      logic [31:0] w, exp_ir;
      logic [15:0] mpc, raddr, rp;
      bit run, hlt, infl, drop, exp_req, st, rdy, rd, v;
      int pe0;
      for (int a = 0; a < 65536; a++) begin
         w = $urandom;
         if (w[3:0] == 4'h0) w[31:27] = 5'b11111;
         else if (w[31:27] == 5'b11111) w[31] = 1'b0;
         memw[a] = w;
      end
      do_reset();
      mem_rand = 1'b1; pe0 = proto_err;
      mpc = RESET_PC; raddr = '0; run = 0; hlt = 0; infl = 0; drop = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         exp_req = run && !hlt && !infl && (q.size() < DEPTH);
         exp_ir  = (q.size() != 0) ? q[0] : 32'h0;
         checks++; if (pc !== mpc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, pc, mpc); end
         checks++; if (ir_valid !== (q.size() != 0) || ir !== exp_ir) begin failures++; $display("FAIL rnd_ir cyc=%0d got=%0b/%h exp=%0b/%h", cyc, ir_valid, ir, q.size() != 0, exp_ir); end
         checks++; if (halted !== (hlt && q.size() == 0)) begin failures++; $display("FAIL rnd_halted cyc=%0d got=%0b exp=%0b", cyc, halted, hlt && q.size() == 0); end
         checks++; if (imem_req !== exp_req || imem_addr !== (exp_req ? mpc : 16'h0)) begin
            failures++; $display("FAIL rnd_req cyc=%0d got=%0b/%h exp=%0b/%h", cyc, imem_req, imem_addr, exp_req, exp_req ? mpc : 16'h0);
         end
         st = ($urandom % 4) == 0; rdy = ($urandom % 10) < 6; rd = ($urandom % 32) == 0; rp = 16'($urandom);
         start = st; ir_ready = rdy; redirect_en = rd; redirect_pc = rp;
         @(posedge clk);
         v = imem_valid;
         if (rdy && q.size() != 0) void'(q.pop_front());
         if (!run) begin
            if (rd) mpc = rp;
            if (st) run = 1;
         end else begin
            if (exp_req) begin infl = 1; drop = 0; raddr = mpc; end
            if (v && infl) begin
               infl = 0;
               if (!drop && !rd) begin
                  mpc = mpc + 16'd1;
                  if (memw[raddr][31:27] == 5'b11111) hlt = 1;
                  else q.push_back(memw[raddr]);
               end
               drop = 0;
            end
            if (rd) begin
               q.delete(); mpc = rp; hlt = 0;
               if (infl) drop = 1;
            end
         end
         @(negedge clk);
      end
      checks++; if (proto_err != pe0) begin failures++; $display("FAIL rnd_outstanding got=%0d exp=%0d", proto_err, pe0); end
      mem_rand = 1'b0; redirect_en = 1'b0; start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rst = 1'b0; start = 1'b0; ir_ready = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
      imem_valid = 1'b0; imem_rdata = '0;
      for (int a = 0; a < 65536; a++) memw[a] = {5'b00001, 11'h0, 16'(a)};
      test_reset();
      test_straight_line();
      test_backpressure();
      test_halt();
      test_redirect_wait();
      test_redirect_pop();
      test_wrap_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the execute stage: fetches 32-bit instruction words from instruction memory.
- Buffers the words in a small FIFO and presents them to execute as IR with a valid/ready handshake.
- Owns the program counter. Supports a redirect (flush and new PC) and stops fetching on a HALT opcode.
- Single outstanding memory request; memory latency is variable (≥1 cycle).

Parameters:
- ADDR_W, 16, width of PC and imem_addr (word address).
- DEPTH, 2, instruction buffer entries (≥2, power of two).
- RESET_PC, 0, PC value after reset.
- HALT_OP, 5'b11111, value of IR[31:27] that stops fetching.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- sys_rst  in  1  reset, asynchronous, active-low.
- start  in  1  in IDLE, begin fetching at the current PC.
- imem_req  out  1  one-cycle request pulse.
- imem_addr  out  ADDR_W  address qualified by imem_req.
- imem_rdata  in  32  instruction word, qualified by imem_valid.
- imem_valid  in  1  response strobe, ≥1 cycle after imem_req.
- ir  out  32  buffer head instruction.
- ir_valid  out  1  buffer not empty.
- ir_ready  in  1  execute stage accepts ir this cycle.
- redirect_en  in  1  flush and restart at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address.
- pc  out  ADDR_W  address of next word to fetch.
- halted  out  1  HALT fetched and buffer drained.

Behaviour:
- Reset (sys_rst=0, asynchronous):
  - State IDLE, pc=RESET_PC, buffer empty.
  - imem_req=0, imem_addr=0, ir=0, ir_valid=0, halted=0, discard flag cleared.
- States: IDLE, ISSUE, WAIT, STALL, DRAIN, HALT.
- IDLE: outputs quiescent. start=1 → ISSUE. redirect_en in IDLE loads pc but stays in IDLE.
- ISSUE:
  - imem_req=1, imem_addr=pc for exactly one cycle, then → WAIT.
  - ISSUE is only entered when buffer count < DEPTH.
- WAIT: on imem_valid, pc ← pc+1 (wraps from 2^ADDR_W−1 to 0), then:
  - If imem_rdata[31:27]==HALT_OP: word is not pushed → HALT.
  - Else the word is pushed. If post-push count < DEPTH → ISSUE, else → STALL.
- STALL: → ISSUE in the first cycle count < DEPTH (a pop in that cycle counts).
- Buffer:
  - ir = head entry; ir_valid = (count≠0).
  - Pop when ir_valid && ir_ready.
  - Push and pop in the same cycle are legal: count unchanged, order preserved.
  - Push never occurs when full (guaranteed by the ISSUE rule).
- Redirect (redirect_en=1 in any state except IDLE):
  - Buffer flushed (count=0, ir_valid=0 next cycle), pc ← redirect_pc, halted ← 0.
  - A pop in the same cycle is treated as accepted before the flush.
  - In WAIT without imem_valid: set discard flag → DRAIN.
  - In WAIT with imem_valid the same cycle: response dropped → ISSUE.
  - In ISSUE: the pulse already driven is outstanding → DRAIN.
  - In STALL or HALT: → ISSUE.
- DRAIN: wait for imem_valid, drop the data, clear discard → ISSUE. A redirect here updates pc and stays in DRAIN.
- HALT: no requests. halted=1 when count==0. Only a redirect leaves HALT; start is ignored outside IDLE.
- pc is never advanced by a discarded response.
- ir holds its value when not popped and is zero after reset or flush.

Test Plan:
- Straight-line fetch: memory returns 0x08400005, 0x10820001, 0x20000000 with 1-cycle latency, ir_ready=1 → ir presents the three words in order, each ir_valid one cycle. pc ends at RESET_PC+3, imem_addr sequence 0,1,2.
- Backpressure: ir_ready=0, DEPTH=2 → exactly two requests issued, FSM in STALL, imem_req low. Raise ir_ready for one cycle → one pop, one new ISSUE next cycle.
- HALT: third word 0xF8000000 → not presented on ir, no further imem_req. halted=1 once the two prior words are popped.
- Redirect mid-wait: redirect_pc=0x0040 asserted while the response is outstanding (3-cycle latency) → that response is dropped, next imem_addr=0x0040, buffer flushed, pc=0x0041 after the next response.
- Redirect coincident with imem_valid and a pop → popped word consumed, returned word dropped, ISSUE at redirect_pc the next cycle.
- Wrap and reset: pc=0xFFFF fetch → pc=0x0000. Assert sys_rst mid-WAIT → all outputs to reset values immediately (asynchronous). A late imem_valid after release in IDLE is ignored.
